l2_rsp_arbiter: RTL

L2_RSP_ARBITER -- requirements
Module: l2_rsp_arbiter

---
 rtl/l2_rsp_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/l2_rsp_arbiter.sv
// l2_rsp_arbiter
// Merges the response streams of NUM_L2CACHE L2 banks into a single
// registered output stream. A round-robin pointer picks the first valid
// bank at or after the pointer, and the pointer moves past the winner
// only when a beat is actually accepted.
//
// Optional feature macro: L2_RSP_ARB_CNT_EN
//   When defined, the block also keeps a 16-bit saturating counter of
//   accepted beats for each bank, which cnt_clr_i can clear.
//
// Ports
//   clk                clock; all state changes on its rising edge
//   rst                synchronous, active-high reset
//   rsp_in_valid_i     per-bank response valid
//   rsp_in_ready_o     per-bank response ready (one-hot or zero)
//   rsp_in_payload_i   packed bank payloads; bank i is at [(i+1)*PLD_W-1 -: PLD_W]
//   rsp_out_valid_o    registered merged valid
//   rsp_out_ready_i    downstream ready
//   rsp_out_payload_o  registered merged payload
//   rsp_out_bank_o     index of the bank that sourced the current output beat
//   cnt_clr_i          (L2_RSP_ARB_CNT_EN only) clears the per-bank counters
//   grant_cnt_o        (L2_RSP_ARB_CNT_EN only) bank i counter at [i*16 +: 16]
module l2_rsp_arbiter #(
  parameter  int NUM_L2CACHE = 4,
  parameter  int PLD_W       = 582,
  localparam int BANK_W      = (NUM_L2CACHE > 1) ? $clog2(NUM_L2CACHE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_L2CACHE-1:0]       rsp_in_valid_i,
  output logic [NUM_L2CACHE-1:0]       rsp_in_ready_o,
  input  logic [NUM_L2CACHE*PLD_W-1:0] rsp_in_payload_i,
  output logic                         rsp_out_valid_o,
  input  logic                         rsp_out_ready_i,
  output logic [PLD_W-1:0]             rsp_out_payload_o,
  output logic [BANK_W-1:0]            rsp_out_bank_o
`ifdef L2_RSP_ARB_CNT_EN
  ,
  input  logic                         cnt_clr_i,
  output logic [NUM_L2CACHE*16-1:0]    grant_cnt_o
`endif
);

  logic [BANK_W-1:0]      r_ptr;
  logic                   r_outValid;
  logic [PLD_W-1:0]       r_outPayload;
  logic [BANK_W-1:0]      r_outBank;

  logic                   w_load;
  logic                   w_anyValid;
  logic                   w_accept;
  logic [NUM_L2CACHE-1:0] w_grant;
  logic [BANK_W-1:0]      w_grantIdx;
  logic [BANK_W-1:0]      w_nextPtr;
  logic [PLD_W-1:0]       w_bankPld [NUM_L2CACHE];

  // Unpack the flat payload bus so the winner can be selected by index.
  for (genvar b = 0; b < NUM_L2CACHE; b++) begin : g_unpack
    assign w_bankPld[b] = rsp_in_payload_i[b*PLD_W +: PLD_W];
  end

  // The output stage can take a new beat when it is empty or being drained.
  assign w_load   = !r_outValid || rsp_out_ready_i;
  assign w_accept = w_load && w_anyValid && !rst;

  // Round-robin search: walk upward from the pointer, wrapping at
  // NUM_L2CACHE, and stop at the first valid bank. Only the valid bits and
  // the pointer feed this search, so the grant never depends on payload.
  always_comb begin
    int cand;
    cand       = 0;
    w_grant    = '0;
    w_grantIdx = '0;
    w_anyValid = 1'b0;
    for (int k = 0; k < NUM_L2CACHE; k++) begin
      cand = int'(r_ptr) + k;
      if (cand >= NUM_L2CACHE) cand = cand - NUM_L2CACHE;
      if (!w_anyValid && rsp_in_valid_i[BANK_W'(cand)]) begin
        w_anyValid                 = 1'b1;
        w_grantIdx                 = BANK_W'(cand);
        w_grant[BANK_W'(cand)]     = 1'b1;
      end
    end
  end

  // The pointer moves just past the winner and wraps back to bank 0.
  // With a single bank this always resolves to 0.
  assign w_nextPtr = (int'(w_grantIdx) == NUM_L2CACHE - 1) ? '0 : w_grantIdx + 1'b1;

  // Ready is suppressed during reset so no beat is lost in a reset cycle.
  assign rsp_in_ready_o = (w_load && !rst) ? w_grant : '0;

  // Output register and pointer. A beat that is pending when reset arrives
  // is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid   <= 1'b0;
      r_outPayload <= '0;
      r_outBank    <= '0;
      r_ptr        <= '0;
    end else if (w_load) begin
      r_outValid <= w_anyValid;
      if (w_anyValid) begin
        r_outPayload <= w_bankPld[w_grantIdx];
        r_outBank    <= w_grantIdx;
        r_ptr        <= w_nextPtr;
      end
    end
  end

  assign rsp_out_valid_o   = r_outValid;
  assign rsp_out_payload_o = r_outPayload;
  assign rsp_out_bank_o    = r_outBank;

`ifdef L2_RSP_ARB_CNT_EN
  logic [15:0] r_cnt [NUM_L2CACHE];

  // Per-bank accepted-beat counters. They saturate at all-ones. A clear
  // that coincides with an accept leaves the accepted bank at 1, so that
  // beat is still counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_L2CACHE; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_L2CACHE; b++) begin
        if (cnt_clr_i) begin
          r_cnt[b] <= (w_accept && w_grant[b]) ? 16'd1 : 16'd0;
        end else if (w_accept && w_grant[b] && (r_cnt[b] != 16'hFFFF)) begin
          r_cnt[b] <= r_cnt[b] + 16'd1;
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_L2CACHE; b++) begin : g_cntOut
    assign grant_cnt_o[b*16 +: 16] = r_cnt[b];
  end
`endif

endmodule
